score_render: RTL
=================

SCORE_RENDER -- requirements
Module: score_render

Interface
REQ-001 Parameter X0, default 10'd16: left pixel column of the score field.
REQ-002 Parameter Y0, default 10'd8: top pixel row of the score field.
REQ-003 Parameter DIGITS, default 4: number of decimal digits rendered, fixed at 4 for this release.
REQ-004 sys_clk  input  1  single system clock; all logic rising-edge.
REQ-005 sys_rst  input  1  asynchronous, active-high reset.
REQ-006 score_i  input  14  binary score value.
REQ-007 score_load  input  1  one-cycle request to convert and display score_i.
REQ-008 busy_o  output  1  conversion in progress; loads ignored.
REQ-009 pix_x  input  10  current scan column from the VGA timing block.
REQ-010 pix_y  input  10  current scan row from the VGA timing block.
REQ-011 digit_o  output  4  BCD digit sent to the glyph ROM's digit select.
REQ-012 glyph_x_o  output  3  column within the 8x8 glyph, to the glyph ROM.
REQ-013 glyph_y_o  output  3  row within the 8x8 glyph, to the glyph ROM.
REQ-014 glyph_bit_i  input  1  combinational pixel bit returned by the glyph ROM for the current digit_o, glyph_x_o and glyph_y_o.
REQ-015 pix_on_o  output  1  score foreground pixel, aligned 2 cycles after pix_x and pix_y.

Function
REQ-016 FSM states: IDLE, SHIFT, COMMIT; busy_o = (state != IDLE).
REQ-017 IDLE with score_load=1: latch min(score_i, 9999), clear the BCD shift register, load shift counter 13, go to SHIFT.
REQ-018 SHIFT: one double-dabble step per cycle (add 3 to each nibble >=5, then shift left 1 with the next binary MSB in); exit to COMMIT after 14 steps.
REQ-019 COMMIT: copy the 16-bit BCD result to the display register in one cycle; return to IDLE.
REQ-020 Timing: load sampled at cycle n; busy_o high for cycles n+1..n+15; display register holds the new value from cycle n+16.
REQ-021 score_load while busy_o=1: ignored, no queuing; the display keeps its old value until COMMIT.
REQ-022 Display register changes only in COMMIT, so a frame never shows partial BCD.
REQ-023 Field region: X0 <= pix_x < X0+8*DIGITS and Y0 <= pix_y < Y0+8; all compares use 10-bit unsigned arithmetic, with no wrap past 1023.
REQ-024 Stage 1 (registered):
- digit index k = (pix_x-X0)>>3, with k=0 the most significant digit;
- digit_o = BCD nibble k;
- glyph_x_o = (pix_x-X0)[2:0];
- glyph_y_o = (pix_y-Y0)[2:0];
- region flag registered.
REQ-025 Outside the region, stage 1 drives digit_o=0, glyph_x_o=0 and glyph_y_o=0, and the region flag is 0.
REQ-026 Stage 2 (registered): pix_on_o = region_flag_d1 & glyph_bit_i & ~blank_d1, giving a fixed latency of 2 cycles.
REQ-027 Rendering runs continuously and independently of the FSM state.

Reset
REQ-028 On sys_rst=1, asynchronously: state=IDLE, busy_o=0, display register=0000, BCD shift register=0, digit_o=0, glyph_x_o=0, glyph_y_o=0, pix_on_o=0, pipeline flags=0.
REQ-029 Reset during SHIFT or COMMIT aborts the conversion; display reads 0000 afterwards.
REQ-030 First score_load accepted on the first rising edge after sys_rst deasserts.

Configuration
REQ-031 Macro SCORE_LEADING_ZERO_BLANK_EN: when defined, a leading-zero digit (every more significant digit also zero, and k != DIGITS-1) sets blank for that digit, so 0042 renders as "  42" and 0000 renders as "   0".
REQ-032 Without SCORE_LEADING_ZERO_BLANK_EN: blank is constant 0 and all DIGITS digits render, zeros included.

Verification
REQ-033 Reset, then score_i=1234 with a 1-cycle load -> busy_o high exactly 15 cycles; display register 0x1234 at n+16.
REQ-034 score_i=16383 load -> display 0x9999 (saturation).
REQ-035 Load 5678 then load 42 at n+5 -> second load ignored; display 0x5678; a later load of 42 after busy_o falls gives 0x0042.
REQ-036 Display 0x0907, scan pix_y=Y0+3, pix_x=X0..X0+31 with a model glyph ROM -> digit_o sequence 0,9,0,7 (8 cycles each); pix_on_o equals the model bit 2 cycles later; pix_x=X0-1 and pix_x=X0+32 give pix_on_o=0.
REQ-037 Assert sys_rst at SHIFT step 7 of a load of 9999 -> all outputs 0 immediately; display 0x0000; a next load of 1 gives 0x0001.
REQ-038 With SCORE_LEADING_ZERO_BLANK_EN, display 0x0042 -> pix_on_o=0 across digits 0-1; digits 2-3 match the ROM; without the macro, the glyph "0" appears in digits 0-1.

Source files
------------

// File: rtl/score_render.sv
// score_render: converts a 14-bit binary score to four BCD digits with a
// serial double-dabble FSM, and renders them as an 8x8-glyph score field
// for a VGA scan through a two-stage pixel pipeline.
// Optional feature: define SCORE_LEADING_ZERO_BLANK_EN to blank leading
// zero digits (the least significant digit is always shown).
module score_render #(
  parameter logic [9:0] X0     = 10'd16,
  parameter logic [9:0] Y0     = 10'd8,
  parameter int         DIGITS = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] score_i,
  input  logic        score_load,
  output logic        busy_o,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [3:0]  digit_o,
  output logic [2:0]  glyph_x_o,
  output logic [2:0]  glyph_y_o,
  input  logic        glyph_bit_i,
  output logic        pix_on_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  // Field bounds are widened to 11 bits so X0+8*DIGITS cannot wrap past 1023.
  localparam logic [10:0] XEnd = {1'b0, X0} + 11'(8 * DIGITS);
  localparam logic [10:0] YEnd = {1'b0, Y0} + 11'd8;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcdAdj;
  logic        unusedMsb;

  logic        inRegion;
  logic [4:0]  dx;
  logic [2:0]  dy;
  logic [1:0]  digitIdx;
  logic [3:0]  nibble;
  logic [3:0]  digit_q, digit_d;
  logic [2:0]  gx_q, gx_d;
  logic [2:0]  gy_q, gy_d;
  logic        region_q, region_d;
  logic        blank_q, blank_d;
  logic        pixOn_q, pixOn_d;

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcdAdj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next state: latch saturated score, 14 shift steps, then commit.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    disp_d    = disp_q;
    cnt_d     = cnt_q;
    unusedMsb = 1'b0;
    case (state_q)
      IDLE: begin
        if (score_load) begin
          bin_d   = (score_i > 14'd9999) ? 14'd9999 : score_i;
          bcd_d   = 16'd0;
          cnt_d   = 4'd13;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {unusedMsb, bcd_d} = {bcdAdj, bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        if (cnt_q == 4'd0) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      COMMIT: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Conversion state registers; the display only ever changes in COMMIT.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      bin_q   <= 14'd0;
      bcd_q   <= 16'd0;
      disp_q  <= 16'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != IDLE);

  // Low-bit offsets are exact inside the field, which is all that matters here.
  assign dx       = pix_x[4:0] - X0[4:0];
  assign dy       = pix_y[2:0] - Y0[2:0];
  assign digitIdx = dx[4:3];
  assign inRegion = ({1'b0, pix_x} >= {1'b0, X0}) && ({1'b0, pix_x} < XEnd) &&
                    ({1'b0, pix_y} >= {1'b0, Y0}) && ({1'b0, pix_y} < YEnd);

  // Stage 1 next values: pick the digit under the beam and the glyph coordinates.
  always_comb begin
    nibble   = 4'd0;
    digit_d  = 4'd0;
    gx_d     = 3'd0;
    gy_d     = 3'd0;
    region_d = 1'b0;
    blank_d  = 1'b0;
    case (digitIdx)
      2'd0:    nibble = disp_q[15:12];
      2'd1:    nibble = disp_q[11:8];
      2'd2:    nibble = disp_q[7:4];
      default: nibble = disp_q[3:0];
    endcase
    if (inRegion) begin
      digit_d  = nibble;
      gx_d     = dx[2:0];
      gy_d     = dy;
      region_d = 1'b1;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      case (digitIdx)
        2'd0:    blank_d = (disp_q[15:12] == 4'd0);
        2'd1:    blank_d = (disp_q[15:8] == 8'd0);
        2'd2:    blank_d = (disp_q[15:4] == 12'd0);
        default: blank_d = 1'b0;
      endcase
`else
      blank_d = 1'b0;
`endif
    end
  end

  // Stage 2 next value: combine the glyph ROM bit with the delayed region/blank flags.
  always_comb begin
    pixOn_d = region_q & glyph_bit_i & ~blank_q;
  end

  // Render pipeline registers, running independently of the conversion FSM.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      digit_q  <= 4'd0;
      gx_q     <= 3'd0;
      gy_q     <= 3'd0;
      region_q <= 1'b0;
      blank_q  <= 1'b0;
      pixOn_q  <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      region_q <= region_d;
      blank_q  <= blank_d;
      pixOn_q  <= pixOn_d;
    end
  end

  assign digit_o   = digit_q;
  assign glyph_x_o = gx_q;
  assign glyph_y_o = gy_q;
  assign pix_on_o  = pixOn_q;

endmodule
